scan_chain_ctrl: RTL and testbench

//  Drives one mux-scan chain built from SDFCNQD1-style cells (SE=1 shifts SI->Q, SE=0 captures D).

---
 rtl/scan_ctrl_pkg.sv | 20 ++
 rtl/scan_cnt.sv | 35 +++
 rtl/scan_chain_ctrl.sv | 135 +++++++++++++
 tb/tb_scan_chain_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types for scan-chain controllers: phase encoding and a counter-width helper.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } scan_state_e;

  // Bits needed to hold the value max_val itself (never less than 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/scan_cnt.sv
// Loadable down-counter shared by all phases of the scan controller.
module scan_cnt #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         is_one_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload sequencer for a single mux-scan chain.
// Valid/ready: start is a request honoured only in IDLE (busy=0); done is a one-cycle result strobe.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 32,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 CP,
  input  logic                 CDN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] unload_data,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output scan_state_e          dbg_state_o
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  // Counter also carries the capture length, which may exceed CHAIN_LEN.
  localparam int CAP_W = cnt_width(CAP_CYCLES);
  localparam int CW    = (CNT_W > CAP_W) ? CNT_W : CAP_W;

  scan_state_e          state_q, state_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;
  logic [CHAIN_LEN-1:0] rx_shift;
  logic                 cnt_load;
  logic [CW-1:0]        cnt_val;
  logic                 cnt_dec;
  logic                 cnt_is_one;

  scan_cnt #(
    .W (CW)
  ) u_cnt (
    .clk_i    (CP),
    .rst_ni   (CDN),
    .load_i   (cnt_load),
    .value_i  (cnt_val),
    .dec_i    (cnt_dec),
    .is_one_o (cnt_is_one)
  );

  // SO is the last cell, so each new sample enters at bit 0 and ages toward the MSB.
  generate
    if (CHAIN_LEN == 1) begin : g_rx_one
      assign rx_shift = SO;
    end else begin : g_rx_many
      assign rx_shift = {rx_q[CHAIN_LEN-2:0], SO};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    unload_d = unload_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d     = load_data;
          cnt_load = 1'b1;
          cnt_val  = CW'(CHAIN_LEN);
          state_d  = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        tx_d = tx_q << 1;
        if (cnt_is_one) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(CAP_CYCLES);
          state_d  = CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt_is_one) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(CHAIN_LEN);
          state_d  = SHIFT_OUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SHIFT_OUT: begin
        rx_d    = rx_shift;
        cnt_dec = 1'b1;
        if (cnt_is_one) begin
          unload_d = rx_shift;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (!CDN) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      unload_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      unload_q <= unload_d;
    end
  end

  // Pin outputs depend only on registered state, keeping the chain pins glitch-free.
  always_comb begin
    SE   = (state_q == SHIFT_IN) || (state_q == SHIFT_OUT);
    SI   = (state_q == SHIFT_IN) ? tx_q[CHAIN_LEN-1] : 1'b0;
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign unload_data = unload_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: three instances (32/1, 32/3, 1/1) each driving a modelled scan chain.
module tb_scan_chain_ctrl;
  import scan_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic cdn = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT instances ----------------
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [31:0] ld_a = '0, ld_b = '0;
  logic        ld_c = 1'b0;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic        se_a, se_b, se_c, si_a, si_b, si_c, so_a, so_b, so_c;
  logic [31:0] ul_a, ul_b;
  logic        ul_c;
  scan_state_e st_a, st_b, st_c;

  scan_chain_ctrl #(.CHAIN_LEN(32), .CAP_CYCLES(1)) u_dut_a (
    .CP(clk), .CDN(cdn), .start(start_a), .load_data(ld_a), .busy(busy_a), .done(done_a),
    .unload_data(ul_a), .SE(se_a), .SI(si_a), .SO(so_a), .dbg_state_o(st_a));
  scan_chain_ctrl #(.CHAIN_LEN(32), .CAP_CYCLES(3)) u_dut_b (
    .CP(clk), .CDN(cdn), .start(start_b), .load_data(ld_b), .busy(busy_b), .done(done_b),
    .unload_data(ul_b), .SE(se_b), .SI(si_b), .SO(so_b), .dbg_state_o(st_b));
  scan_chain_ctrl #(.CHAIN_LEN(1), .CAP_CYCLES(1)) u_dut_c (
    .CP(clk), .CDN(cdn), .start(start_c), .load_data(ld_c), .busy(busy_c), .done(done_c),
    .unload_data(ul_c), .SE(se_c), .SI(si_c), .SO(so_c), .dbg_state_o(st_c));

  // ---------------- scan chain models (SE=1 shift, SE=0 capture D) ----------------
  int          cap_mode = 0;  // 0: D=Q, 1: D=~Q, 2: D=DEAD_BEEF
  logic [31:0] ch_a = '0, ch_b = '0;
  logic        ch_c = 1'b0;

  function automatic logic [31:0] cap_fn(input logic [31:0] q);
    case (cap_mode)
      0:       return q;
      1:       return ~q;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    ch_a <= se_a ? {ch_a[30:0], si_a} : cap_fn(ch_a);
    ch_b <= se_b ? {ch_b[30:0], si_b} : cap_fn(ch_b);
    ch_c <= se_c ? si_c : ((cap_mode == 1) ? ~ch_c : ch_c);
  end
  assign so_a = ch_a[31];
  assign so_b = ch_b[31];
  assign so_c = ch_c;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_id_q[$];
  int          lens[3] = '{32, 32, 1};
  int          caps[3] = '{1, 3, 1};
  int          se_hi[3] = '{0, 0, 0};
  int          se_lo[3] = '{0, 0, 0};
  int          done_cnt[3] = '{0, 0, 0};
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic sb_check(input int d, input logic [31:0] act, input int hi, input int lo);
    logic [31:0] e;
    int          ec;
    int          ei;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: dut=%0d got=%0h expected=no done", d, act);
    end else begin
      e  = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      ei = exp_id_q.pop_front();
      chk("done_dut", d, ei);
      chk("unload_data", act, e);
      chk("done_cycle", cyc, ec);
      chk("se_high_cycles", hi, 2 * lens[d]);
      chk("se_low_capture", lo, caps[d]);
    end
  endtask

  task automatic mon(input int d, input logic b, input logic dn, input logic se,
                     input logic [31:0] ul);
    if (!b) begin
      se_hi[d] = 0;
      se_lo[d] = 0;
    end else if (dn) begin
      done_cnt[d]++;
      sb_check(d, ul, se_hi[d], se_lo[d]);
    end else if (se) begin
      se_hi[d]++;
    end else begin
      se_lo[d]++;
    end
  endtask

  // Monitor: decoupled from stimulus, pops whenever a DUT raises done.
  always @(negedge clk) begin
    mon(0, busy_a, done_a, se_a, ul_a);
    mon(1, busy_b, done_b, se_b, ul_b);
    mon(2, busy_c, done_c, se_c, {31'b0, ul_c});
  end

  // ---------------- driver tasks ----------------
  function automatic logic is_busy(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    while (is_busy(d) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (is_busy(d)) chk("idle_timeout", 1, 0);
  endtask

  // Done is visible in the cycle right after edge t+2L+C, where t is the accepting edge.
  task automatic push_exp(input int d, input logic [31:0] v);
    exp_q.push_back(v);
    exp_cyc_q.push_back(cyc + 1 + 2 * lens[d] + caps[d]);
    exp_id_q.push_back(d);
  endtask

  task automatic issue(input int d, input logic [31:0] data, input logic [31:0] expv,
                       input bit push);
    wait_idle(d);
    case (d)
      0:       begin start_a = 1'b1; ld_a = data; end
      1:       begin start_b = 1'b1; ld_b = data; end
      default: begin start_c = 1'b1; ld_c = data[0]; end
    endcase
    if (push) push_exp(d, expv);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] vec4[3] = '{32'h1111_2222, 32'hCAFE_F00D, 32'h8000_0001};
  int          dc0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_se_a", se_a, 0);
    chk("rst_si_a", si_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_unload_a", ul_a, 0);
    chk("rst_state_b", st_b, IDLE);
    chk("rst_state_c", st_c, IDLE);
    cdn = 1'b1;
    @(negedge clk);

    // Passthrough capture: data returns unchanged.
    cap_mode = 0;
    issue(0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1);
    drain();

    // Inverting capture; previous result must persist during the new sequence.
    cap_mode = 1;
    issue(0, 32'h1234_5678, 32'hEDCB_A987, 1'b1);
    repeat (10) @(negedge clk);
    chk("unload_hold", ul_a, 32'hA5A5_0F0F);
    drain();

    // Fixed capture value with a three-cycle capture window.
    cap_mode = 2;
    issue(1, 32'h0F0F_1234, 32'hDEAD_BEEF, 1'b1);
    drain();

    // start held high for 200 cycles: back-to-back sequences, one IDLE cycle apart.
    cap_mode = 0;
    wait_idle(0);
    dc0 = done_cnt[0];
    start_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i % 67 == 0) begin
        ld_a = vec4[i / 67];
        push_exp(0, vec4[i / 67]);
      end else begin
        ld_a = $urandom;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    drain();
    chk("b2b_done_count", done_cnt[0] - dc0, 3);

    // Reset for one edge in the middle of SHIFT_OUT aborts without a done.
    issue(0, 32'h5555_AAAA, 32'h0, 1'b0);
    repeat (45) @(negedge clk);
    chk("pre_reset_state", st_a, SHIFT_OUT);
    cdn = 1'b0;
    @(negedge clk);
    cdn = 1'b1;
    chk("abort_se", se_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_unload", ul_a, 0);
    chk("abort_state", st_a, IDLE);
    @(negedge clk);
    issue(0, 32'h3C3C_C3C3, 32'h3C3C_C3C3, 1'b1);
    drain();

    // Single-cell chain with inverting capture.
    cap_mode = 1;
    issue(2, 32'h1, 32'h0, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
